// File: rtl/generador_trafico.sv
// Traffic source for the four switch input FIFOs: on start it pushes NUM_PKTS
// deterministic packets into every lane, each lane throttled by its own alm_full.
module generador_trafico #(
    parameter int NUM_PKTS = 8,
    parameter int DATA_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              alm_full_0,
    input  logic              alm_full_1,
    input  logic              alm_full_2,
    input  logic              alm_full_3,
    output logic              push_0,
    output logic              push_1,
    output logic              push_2,
    output logic              push_3,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic              busy,
    output logic              done,
    output logic [4:0]        sent_0,
    output logic [4:0]        sent_1,
    output logic [4:0]        sent_2,
    output logic [4:0]        sent_3
);

    localparam int LANES  = 4;
    localparam int REM_W  = 7;
    localparam int SEQ_W  = 6;
    localparam int SENT_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REM_W-1:0]    r_rem  [LANES];
    logic [SEQ_W-1:0]    r_seq  [LANES];
    logic [DATA_W-1:0]   r_data [LANES];
    logic [SENT_W-1:0]   r_sent [LANES];
    logic [LANES-1:0]    r_push;
    logic                r_done;

    logic [LANES-1:0]    w_alm_full;
    logic [LANES-1:0]    w_fire;
    logic [1:0]          w_dest     [LANES];
    logic [DATA_W-1:0]   w_pkt      [LANES];
    logic [2:0]          w_add      [LANES];
    logic [SENT_W:0]     w_sum      [LANES];
    logic [SENT_W-1:0]   w_sent_nxt [LANES];
    logic                w_all_empty;
    logic                w_load;

    assign w_alm_full = {alm_full_3, alm_full_2, alm_full_1, alm_full_0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_all_empty) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load      = (r_state == S_IDLE) && start;
        w_all_empty = 1'b1;
        w_fire      = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_add[i] = '0;
            if (r_rem[i] != '0) w_all_empty = 1'b0;
            w_fire[i] = (r_state == S_RUN) && (r_rem[i] != '0) && !w_alm_full[i];
            w_dest[i] = r_seq[i][1:0] ^ 2'(i);
            w_pkt[i]  = DATA_W'({w_dest[i], 2'(i), r_seq[i]});
        end
        // Several lanes may hit the same destination in one cycle.
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned d = 0; d < LANES; d++) begin
                if (w_fire[i] && (w_dest[i] == 2'(d))) w_add[d] = w_add[d] + 3'd1;
            end
        end
        for (int unsigned d = 0; d < LANES; d++) begin
            w_sum[d]      = {1'b0, r_sent[d]} + {3'b000, w_add[d]};
            w_sent_nxt[d] = w_sum[d][SENT_W] ? '1 : w_sum[d][SENT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_push <= '0;
            r_done <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_rem[i]  <= '0;
                r_seq[i]  <= '0;
                r_data[i] <= '0;
                r_sent[i] <= '0;
            end
        end else begin
            r_push <= w_fire;
            r_done <= (r_state == S_RUN) && w_all_empty;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (w_load) begin
                    r_rem[i]  <= REM_W'(NUM_PKTS);
                    r_seq[i]  <= '0;
                    r_sent[i] <= '0;
                end else begin
                    r_sent[i] <= w_sent_nxt[i];
                    if (w_fire[i]) begin
                        r_rem[i]  <= r_rem[i] - REM_W'(1);
                        r_seq[i]  <= r_seq[i] + SEQ_W'(1);
                        r_data[i] <= w_pkt[i];
                    end
                end
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign push_0 = r_push[0];
    assign push_1 = r_push[1];
    assign push_2 = r_push[2];
    assign push_3 = r_push[3];
    assign data_0 = r_data[0];
    assign data_1 = r_data[1];
    assign data_2 = r_data[2];
    assign data_3 = r_data[3];
    assign sent_0 = r_sent[0];
    assign sent_1 = r_sent[1];
    assign sent_2 = r_sent[2];
    assign sent_3 = r_sent[3];

endmodule

// File: tb/tb_generador_trafico.sv
// Bench for generador_trafico: a 4-packet and a 32-packet instance run directed
// and randomly throttled bursts against a per-cycle behavioural model.
module tb_generador_trafico;

    localparam int NA = 4;
    localparam int NB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] af = '0;

    logic [3:0] pa, pb;
    logic [9:0] da [4];
    logic [9:0] db [4];
    logic [4:0] sa [4];
    logic [4:0] sb [4];
    logic       busy_a, busy_b, done_a, done_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc [2];
    bit log_en = 1'b0;
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    int m_st   [2];
    int m_rem  [2][4];
    int m_seq  [2][4];
    int m_push [2][4];
    int m_data [2][4];
    int m_sent [2][4];
    int m_done [2];

    always #5 clk = ~clk;

    generador_trafico #(.NUM_PKTS(NA), .DATA_W(10)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .alm_full_0(af[0]), .alm_full_1(af[1]), .alm_full_2(af[2]), .alm_full_3(af[3]),
        .push_0(pa[0]), .push_1(pa[1]), .push_2(pa[2]), .push_3(pa[3]),
        .data_0(da[0]), .data_1(da[1]), .data_2(da[2]), .data_3(da[3]),
        .busy(busy_a), .done(done_a),
        .sent_0(sa[0]), .sent_1(sa[1]), .sent_2(sa[2]), .sent_3(sa[3])
    );

    generador_trafico #(.NUM_PKTS(NB), .DATA_W(10)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .alm_full_0(af[0]), .alm_full_1(af[1]), .alm_full_2(af[2]), .alm_full_3(af[3]),
        .push_0(pb[0]), .push_1(pb[1]), .push_2(pb[2]), .push_3(pb[3]),
        .data_0(db[0]), .data_1(db[1]), .data_2(db[2]), .data_3(db[3]),
        .busy(busy_b), .done(done_b),
        .sent_0(sb[0]), .sent_1(sb[1]), .sent_2(sb[2]), .sent_3(sb[3])
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0;
            m_done[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_rem[k][i] = 0; m_seq[k][i] = 0; m_push[k][i] = 0;
                m_data[k][i] = 0; m_sent[k][i] = 0;
            end
        end
    endfunction

    // Model states: 0 idle, 1 running, 2 finishing.
    function automatic void model_edge(int k, logic s);
        int n;
        int dest;
        int left;
        n = (k == 0) ? NA : NB;
        case (m_st[k])
            0: begin
                if (s) begin
                    m_st[k] = 1;
                    for (int i = 0; i < 4; i++) begin
                        m_rem[k][i] = n; m_seq[k][i] = 0; m_sent[k][i] = 0;
                    end
                end
            end
            1: begin
                left = 0;
                for (int i = 0; i < 4; i++) left += m_rem[k][i];
                if (left == 0) begin
                    for (int i = 0; i < 4; i++) m_push[k][i] = 0;
                    m_done[k] = 1;
                    m_st[k] = 2;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_rem[k][i] > 0 && af[i] == 1'b0) begin
                            dest = (m_seq[k][i] ^ i) & 3;
                            m_push[k][i] = 1;
                            m_data[k][i] = dest * 256 + i * 64 + (m_seq[k][i] % 64);
                            m_seq[k][i]++;
                            m_rem[k][i]--;
                            if (m_sent[k][dest] < 31) m_sent[k][dest]++;
                        end else begin
                            m_push[k][i] = 0;
                        end
                    end
                end
            end
            default: begin
                m_done[k] = 0;
                m_st[k] = 0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input int lane,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d lane=%0d observed=0x%0h expected=0x%0h", tag, k, lane, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("busy", k, 0, 32'((k == 0) ? busy_a : busy_b), 32'(m_st[k] != 0));
            chk("done", k, 0, 32'((k == 0) ? done_a : done_b), 32'(m_done[k]));
            for (int i = 0; i < 4; i++) begin
                chk("push", k, i, 32'((k == 0) ? pa[i] : pb[i]), 32'(m_push[k][i]));
                chk("data", k, i, 32'((k == 0) ? da[i] : db[i]), 32'(m_data[k][i]));
                chk("sent", k, i, 32'((k == 0) ? sa[i] : sb[i]), 32'(m_sent[k][i]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_edge(0, start_a);
            model_edge(1, start_b);
        end else begin
            model_reset();
        end
        cyc++;
        #1;
        check_all();
        if (done_a) done_cyc[0] = cyc;
        if (done_b) done_cyc[1] = cyc;
        if (log_en) begin
            if (pa[0]) q0.push_back(da[0]);
            if (pa[1]) q1.push_back(da[1]);
        end
    endtask

    task automatic run_to_idle(input int k, input int budget, input bit rnd);
        for (int c = 0; c < budget && m_st[k] != 0; c++) begin
            if (rnd) af = 4'($urandom) & 4'($urandom);
            tick();
        end
        af = '0;
        chk("burst_end_busy", k, 0, 32'((k == 0) ? busy_a : busy_b), 32'd0);
    endtask

    logic [9:0] exp_l0 [4];
    logic [9:0] exp_l1 [4];
    int start_cyc;

    initial begin
        exp_l0 = '{10'h000, 10'h101, 10'h202, 10'h303};
        exp_l1 = '{10'h140, 10'h041, 10'h342, 10'h243};
        model_reset();
        #2 rst = 1'b0;
        #1 check_all();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) tick();

        // Unthrottled 4-packet burst with data-order and latency checks.
        log_en = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        start_cyc = cyc;
        run_to_idle(0, 40, 1'b0);
        log_en = 1'b0;
        chk("done_latency", 0, 0, 32'(done_cyc[0] - start_cyc), 32'(NA + 1));
        chk("lane0_count", 0, 0, 32'(q0.size()), 32'd4);
        chk("lane1_count", 0, 1, 32'(q1.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("lane0_seq", 0, j, 32'(q0[j]), 32'(exp_l0[j]));
            chk("lane1_seq", 0, j, 32'(q1[j]), 32'(exp_l1[j]));
        end
        for (int i = 0; i < 4; i++) chk("sent_total4", 0, i, 32'(sa[i]), 32'd4);

        // Lane 2 held off for three cycles after RUN entry.
        start_a = 1'b1; tick(); start_a = 1'b0;
        start_cyc = cyc;
        af[2] = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        af[2] = 1'b0;
        run_to_idle(0, 40, 1'b0);
        chk("done_latency_thr", 0, 0, 32'(done_cyc[0] - start_cyc), 32'(NA + 4));
        for (int i = 0; i < 4; i++) chk("sent_total4_thr", 0, i, 32'(sa[i]), 32'd4);

        // 32-packet burst under random throttling: counters saturate.
        start_b = 1'b1; tick(); start_b = 1'b0;
        run_to_idle(1, 400, 1'b1);
        for (int i = 0; i < 4; i++) chk("sent_sat", 1, i, 32'(sb[i]), 32'd31);

        // Start re-pulsed while running must not reload the burst.
        start_a = 1'b1; tick(); start_a = 1'b0;
        af = 4'($urandom) & 4'($urandom); tick();
        af = '0; tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        run_to_idle(0, 60, 1'b1);
        for (int i = 0; i < 4; i++) chk("sent_single_burst", 0, i, 32'(sa[i]), 32'd4);

        // Asynchronous reset two cycles into a burst.
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        #1 check_all();
        chk("rst_push", 1, 0, 32'(pb), 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_sent", 1, i, 32'(sb[i]), 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("post_rst_push", 1, 0, 32'(pb), 32'd0);
        chk("post_rst_busy", 1, 0, 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
